ufp_write_combiner: RTL and testbench
=====================================

// Module: ufp_write_combiner
// PURPOSE
//  Parametrised write-combining stage between the UFP store path and the cache data array.
//  Holds one pending line-sized entry and merges successive masked word stores to the same set/way.
//  Writes the entry to the data array as one full-line write with a byte mask. Drain causes:
//  conflicting store, explicit flush, full line, or idle timeout.
//  Sits after the hit/way-select logic; presents pend_* so the read path can stall on a hazard.
// PARAMETERS
//  WAYS        4   associativity; WAY_W = $clog2(WAYS)
//  SETS        16  sets per way; SET_W = $clog2(SETS)
//  LINE_BYTES  32  line size; OFFSET_W = $clog2(LINE_BYTES)
//  WORD_BYTES  4   store word size; must divide LINE_BYTES; WB_W = $clog2(WORD_BYTES)
//  IDLE_MAX    15  idle HOLD cycles before auto-drain; 0 disables the timeout
// PORTS
//  clk         in   1                 clock, all state on rising edge
//  rst_n       in   1                 asynchronous active-low reset
//  req_valid   in   1                 store request valid
//  req_ready   out  1                 store accepted when req_valid & req_ready
//  req_set     in   SET_W             target set
//  req_way     in   WAY_W             target way (binary)
//  req_offset  in   OFFSET_W          byte offset in line; low WB_W bits ignored
//  req_wdata   in   WORD_BYTES*8      store data
//  req_wmask   in   WORD_BYTES        byte enables
//  flush       in   1                 single-cycle pulse: drain pending entry
//  flush_done  out  1                 one-cycle pulse: flush complete
//  arr_valid   out  1                 data-array line write request
//  arr_ready   in   1                 array accepts write when arr_valid & arr_ready
//  arr_set     out  SET_W             write set
//  arr_way     out  WAYS              one-hot way enable
//  arr_wdata   out  LINE_BYTES*8      line data; unmasked bytes are 0
//  arr_wmask   out  LINE_BYTES        line byte mask
//  pend_valid  out  1                 entry held (HOLD or DRAIN)
//  pend_set    out  SET_W             set of pending entry
//  pend_way    out  WAY_W             way of pending entry
// BEHAVIOUR
//  Reset (async assert): state EMPTY, buffer data/mask, counter and flush latch cleared.
//   All outputs 0 except req_ready = 1.
//  Placement: word index w = req_offset[OFFSET_W-1:WB_W].
//   Byte i of the word maps to line byte w*WORD_BYTES+i. Only bytes with mask set are written.
//   Mask bit set: data byte replaced, line mask bit set. Earlier bytes otherwise retained.
//  match = req_set==buf_set && req_way==buf_way. req_ready is combinational:
//   EMPTY -> 1.
//   HOLD  -> match.
//   DRAIN -> 0.
//  EMPTY: on accept, load entry (mask = placed bytes only), counter = 0, go HOLD.
//  HOLD: on accept, merge and reset counter to 0; otherwise increment the counter.
//   Go DRAIN next cycle if any of the following holds:
//   - req_valid & !match (request stalls)
//   - flush
//   - post-merge mask all ones
//   - IDLE_MAX != 0 and counter == IDLE_MAX
//  Merge and flush in the same cycle: the merged data is included in the drain.
//  DRAIN: arr_valid = 1. arr_* are driven from registers and held stable until arr_ready.
//   On handshake: clear buffer, go EMPTY, accept nothing that cycle.
//  arr_valid and arr_way are 0 outside DRAIN.
//  flush latch: set by flush in HOLD/DRAIN, cleared on drain handshake.
//   flush_done pulses the cycle after that handshake.
//   flush in EMPTY: flush_done pulses the next cycle.
//  Latency: accept-to-array minimum 1 cycle (flush with the accepting store -> arr_valid next cycle).
//  Reset mid-DRAIN: pending entry discarded, no write issued, flush_done not pulsed.
// TESTING
//  1 Reset mid-operation -> all outputs 0, req_ready=1, pend_valid=0 immediately (async).
//  2 Merge + flush:
//    - Stimulus: set 3/way 1 stores. off 0x00 mask F data 0x11111111; off 0x04 mask 3 data 0x00002222; then flush.
//    - Response: one arr write. arr_way=4'b0010, arr_wmask=32'h0000003F, arr_wdata[63:0]=64'h00002222_11111111.
//    - flush_done one cycle after arr_ready.
//  3 Overlap: off 0x08 mask F 0xAAAAAAAA then off 0x08 mask 2 0x0000BB00 -> drained word 0xAAAABBAA.
//  4 Conflict: HOLD set 3, request set 4 -> req_ready=0, DRAIN set 3.
//    - arr_ready low 3 cycles: arr_* stable.
//    - After handshake the set-4 store is accepted next cycle.
//  5 Full line: 8 mask-F stores to offsets 0x00..0x1C -> auto-drain, arr_wmask=32'hFFFFFFFF, no flush needed.
//  6 Idle: single store, no traffic, IDLE_MAX=15 -> arr_valid rises 16 cycles after accept.
//    - IDLE_MAX=0: no drain after 100 cycles.

Source files
------------

// File: rtl/ufp_write_combiner.sv
// Write-combining buffer: merges masked word stores to one set/way into a single line write.
// Latency: at least 1 cycle from accept to arr_valid; arr_* come from registers and hold until arr_ready.
// Backpressure: req_ready drops on a set/way conflict and during drain; arr_ready low stalls the drain.
module ufp_write_combiner #(
    parameter int WAYS        = 4,
    parameter int SETS        = 16,
    parameter int LINE_BYTES  = 32,
    parameter int WORD_BYTES  = 4,
    parameter int IDLE_MAX    = 15,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int SET_W      = $clog2(SETS),
    localparam int OFFSET_W   = $clog2(LINE_BYTES),
    localparam int WB_W       = $clog2(WORD_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SET_W-1:0]          req_set,
    input  logic [WAY_W-1:0]          req_way,
    input  logic [OFFSET_W-1:0]       req_offset,
    input  logic [WORD_BYTES*8-1:0]   req_wdata,
    input  logic [WORD_BYTES-1:0]     req_wmask,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      arr_valid,
    input  logic                      arr_ready,
    output logic [SET_W-1:0]          arr_set,
    output logic [WAYS-1:0]           arr_way,
    output logic [LINE_BYTES*8-1:0]   arr_wdata,
    output logic [LINE_BYTES-1:0]     arr_wmask,
    output logic                      pend_valid,
    output logic [SET_W-1:0]          pend_set,
    output logic [WAY_W-1:0]          pend_way
);

    localparam int CNT_W = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_MAX);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [SET_W-1:0]          set_q, set_d;
    logic [WAY_W-1:0]          way_q, way_d;
    logic [LINE_BYTES*8-1:0]   data_q, data_d;
    logic [LINE_BYTES-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      flush_lat_q, flush_lat_d;
    logic                      flush_done_q, flush_done_d;

    logic [OFFSET_W-1:0]       word_idx;
    logic [LINE_BYTES*8-1:0]   place_data;
    logic [LINE_BYTES-1:0]     place_mask;
    logic [LINE_BYTES*8-1:0]   merge_data;
    logic [LINE_BYTES-1:0]     merge_mask;
    logic                      match;
    logic                      timeout;

    assign word_idx = req_offset >> WB_W;
    assign match    = (req_set == set_q) && (req_way == way_q);
    assign timeout  = (IDLE_MAX != 0) && (cnt_q == CNT_MAX);

    // Scatter the incoming word into line position; merged view overlays it on the held line.
    always_comb begin
        place_data = '0;
        place_mask = '0;
        merge_data = data_q;
        merge_mask = mask_q;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if ((int'(word_idx) == (b / WORD_BYTES)) && req_wmask[b % WORD_BYTES]) begin
                place_mask[b]        = 1'b1;
                place_data[b*8 +: 8] = req_wdata[(b % WORD_BYTES)*8 +: 8];
                merge_mask[b]        = 1'b1;
                merge_data[b*8 +: 8] = req_wdata[(b % WORD_BYTES)*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        way_d        = way_q;
        data_d       = data_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        flush_lat_d  = flush_lat_q;
        flush_done_d = 1'b0;
        req_ready    = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                req_ready    = 1'b1;
                flush_done_d = flush;
                if (req_valid) begin
                    set_d   = req_set;
                    way_d   = req_way;
                    data_d  = place_data;
                    mask_d  = place_mask;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                req_ready = match;
                if (req_valid && match) begin
                    data_d = merge_data;
                    mask_d = merge_mask;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (flush) begin
                    flush_lat_d = 1'b1;
                end
                // Full-line check uses the post-merge mask so a completing store drains at once.
                if ((req_valid && !match) || flush || (&mask_d) || timeout) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    flush_lat_d = 1'b1;
                end
                if (arr_ready) begin
                    state_d      = ST_EMPTY;
                    set_d        = '0;
                    way_d        = '0;
                    data_d       = '0;
                    mask_d       = '0;
                    cnt_d        = '0;
                    flush_lat_d  = 1'b0;
                    flush_done_d = flush_lat_q | flush;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            set_q        <= '0;
            way_q        <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            flush_lat_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            way_q        <= way_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            flush_lat_q  <= flush_lat_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign arr_valid  = (state_q == ST_DRAIN);
    assign arr_way    = arr_valid ? (WAYS'(1) << way_q) : '0;
    assign arr_set    = set_q;
    assign arr_wdata  = data_q;
    assign arr_wmask  = mask_q;
    assign pend_valid = (state_q != ST_EMPTY);
    assign pend_set   = set_q;
    assign pend_way   = way_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_ufp_write_combiner.sv
// Bench for ufp_write_combiner: directed scenarios plus a randomized run against a byte-array line model.
module tb_ufp_write_combiner;

    localparam int IDLE = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [3:0]   req_set = '0;
    logic [1:0]   req_way = '0;
    logic [4:0]   req_offset = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_wmask = '0;
    logic         flush = 1'b0;
    logic         arr_ready = 1'b0;

    logic         req_ready, flush_done, arr_valid, pend_valid;
    logic [3:0]   arr_set, pend_set, arr_way;
    logic [1:0]   pend_way;
    logic [255:0] arr_wdata;
    logic [31:0]  arr_wmask;

    logic         req_ready_z, flush_done_z, arr_valid_z, pend_valid_z;
    logic [3:0]   arr_set_z, pend_set_z, arr_way_z;
    logic [1:0]   pend_way_z;
    logic [255:0] arr_wdata_z;
    logic [31:0]  arr_wmask_z;

    int n_vec = 0;
    int n_err = 0;

    // reference model: pending line as byte arrays
    bit          m_pend, m_drain, m_flq, m_fdone;
    logic [3:0]  m_set;
    logic [1:0]  m_way;
    logic [7:0]  m_line [32];
    bit          m_lm   [32];
    int          m_idle;

    ufp_write_combiner #(.IDLE_MAX(IDLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_way(req_way), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .flush(flush), .flush_done(flush_done),
        .arr_valid(arr_valid), .arr_ready(arr_ready),
        .arr_set(arr_set), .arr_way(arr_way), .arr_wdata(arr_wdata), .arr_wmask(arr_wmask),
        .pend_valid(pend_valid), .pend_set(pend_set), .pend_way(pend_way)
    );

    ufp_write_combiner #(.IDLE_MAX(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_z),
        .req_set(req_set), .req_way(req_way), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .flush(flush), .flush_done(flush_done_z),
        .arr_valid(arr_valid_z), .arr_ready(arr_ready),
        .arr_set(arr_set_z), .arr_way(arr_way_z), .arr_wdata(arr_wdata_z), .arr_wmask(arr_wmask_z),
        .pend_valid(pend_valid_z), .pend_set(pend_set_z), .pend_way(pend_way_z)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; arr_ready = 1'b0;
        req_set = '0; req_way = '0; req_offset = '0; req_wdata = '0; req_wmask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_store(input logic [3:0] s, input logic [1:0] w, input logic [4:0] off,
                            input logic [31:0] d, input logic [3:0] m);
        req_valid = 1'b1; req_set = s; req_way = w; req_offset = off; req_wdata = d; req_wmask = m;
        #1;
        for (int k = 0; k < 64 && !req_ready; k++) step();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL store_accept: req_ready=%b after 64 cycles, required 1", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({req_ready, arr_valid, pend_valid, flush_done, arr_way, arr_set, pend_set, pend_way} !== {1'b1, 17'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required %b",
                     {req_ready, arr_valid, pend_valid, flush_done, arr_way, arr_set, pend_set, pend_way}, {1'b1, 17'b0});
        end
        n_vec++;
        if ({arr_wdata, arr_wmask} !== 288'b0) begin
            n_err++;
            $display("FAIL reset_data: wdata=%h wmask=%h required 0", arr_wdata, arr_wmask);
        end
        do_store(4'd5, 2'd2, 5'h0C, 32'hDEADBEEF, 4'hF);
        pulse_flush();
        n_vec++;
        if (arr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_drain: arr_valid=%b required 1", arr_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, arr_valid, pend_valid, flush_done, arr_way, arr_set, pend_set, pend_way, arr_wmask, arr_wdata}
            !== {1'b1, 305'b0}) begin
            n_err++;
            $display("FAIL reset_async: ready=%b valid=%b pend=%b fdone=%b way=%b wmask=%h required 1,0,0,0,0,0",
                     req_ready, arr_valid, pend_valid, flush_done, arr_way, arr_wmask);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        arr_ready = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (arr_valid || flush_done) seen++;
                step();
            end
            n_vec++;
            if (seen != 0) begin
                n_err++;
                $display("FAIL reset_discard: %0d cycles with arr_valid/flush_done after reset, required 0", seen);
            end
        end
        arr_ready = 1'b0;
    endtask

    task automatic test_merge_flush();
        apply_reset();
        do_store(4'd3, 2'd1, 5'h00, 32'h11111111, 4'hF);
        do_store(4'd3, 2'd1, 5'h04, 32'h00002222, 4'h3);
        pulse_flush();
        n_vec++;
        if ({arr_valid, flush_done, arr_set, arr_way} !== {1'b1, 1'b0, 4'd3, 4'b0010}) begin
            n_err++;
            $display("FAIL mf_ctrl: valid=%b fdone=%b set=%0d way=%b required 1,0,3,0010",
                     arr_valid, flush_done, arr_set, arr_way);
        end
        n_vec++;
        if (arr_wmask !== 32'h0000003F) begin
            n_err++;
            $display("FAIL mf_wmask: got %h required 0000003f", arr_wmask);
        end
        n_vec++;
        if (arr_wdata !== {192'b0, 64'h00002222_11111111}) begin
            n_err++;
            $display("FAIL mf_wdata: got %h required 0000222211111111 in low 64 bits, rest 0", arr_wdata);
        end
        arr_ready = 1'b1;
        step();
        arr_ready = 1'b0;
        n_vec++;
        if ({flush_done, arr_valid, pend_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL mf_done: fdone=%b valid=%b pend=%b required 1,0,0", flush_done, arr_valid, pend_valid);
        end
        step();
        n_vec++;
        if (flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL mf_done_pulse: flush_done=%b on second cycle, required 0", flush_done);
        end
        pulse_flush();
        n_vec++;
        if ({flush_done, arr_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL empty_flush: fdone=%b valid=%b required 1,0", flush_done, arr_valid);
        end
    endtask

    task automatic test_overlap();
        apply_reset();
        do_store(4'd3, 2'd1, 5'h08, 32'hAAAAAAAA, 4'hF);
        do_store(4'd3, 2'd1, 5'h08, 32'h0000BB00, 4'h2);
        pulse_flush();
        n_vec++;
        if ({arr_valid, arr_wdata[95:64], arr_wmask} !== {1'b1, 32'hAAAABBAA, 32'h00000F00}) begin
            n_err++;
            $display("FAIL overlap: valid=%b word=%h wmask=%h required 1 aaaabbaa 00000f00",
                     arr_valid, arr_wdata[95:64], arr_wmask);
        end
        arr_ready = 1'b1;
        step();
        arr_ready = 1'b0;
    endtask

    task automatic test_conflict();
        logic [255:0] snap;
        apply_reset();
        do_store(4'd3, 2'd1, 5'h00, 32'h12345678, 4'hF);
        req_valid = 1'b1; req_set = 4'd4; req_way = 2'd1; req_offset = 5'h00;
        req_wdata = 32'h55667788; req_wmask = 4'hF;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_ready: req_ready=%b required 0", req_ready);
        end
        @(posedge clk);
        #1;
        snap = {224'b0, 32'h12345678};
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({arr_valid, req_ready, arr_set, arr_way, arr_wmask, arr_wdata} !==
                {1'b1, 1'b0, 4'd3, 4'b0010, 32'h0000000F, snap}) begin
                n_err++;
                $display("FAIL conflict_hold%0d: valid=%b ready=%b set=%0d way=%b wmask=%h w0=%h required 1,0,3,0010,f,12345678",
                         k, arr_valid, req_ready, arr_set, arr_way, arr_wmask, arr_wdata[31:0]);
            end
            step();
        end
        arr_ready = 1'b1;
        step();
        arr_ready = 1'b0;
        n_vec++;
        if ({req_ready, pend_valid, arr_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL conflict_after: ready=%b pend=%b valid=%b required 1,0,0", req_ready, pend_valid, arr_valid);
        end
        step();
        req_valid = 1'b0;
        n_vec++;
        if ({pend_valid, pend_set, pend_way} !== {1'b1, 4'd4, 2'd1}) begin
            n_err++;
            $display("FAIL conflict_new: pend=%b set=%0d way=%0d required 1,4,1", pend_valid, pend_set, pend_way);
        end
        pulse_flush();
        n_vec++;
        if ({arr_valid, arr_set, arr_wdata[31:0]} !== {1'b1, 4'd4, 32'h55667788}) begin
            n_err++;
            $display("FAIL conflict_drain2: valid=%b set=%0d w0=%h required 1,4,55667788", arr_valid, arr_set, arr_wdata[31:0]);
        end
        arr_ready = 1'b1;
        step();
        arr_ready = 1'b0;
    endtask

    task automatic test_full_line();
        logic [31:0]  d [8];
        logic [255:0] exp_line;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            d[i] = $urandom;
            exp_line[i*32 +: 32] = d[i];
        end
        for (int i = 0; i < 7; i++) do_store(4'd7, 2'd2, 5'(i*4), d[i], 4'hF);
        n_vec++;
        if (arr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_early: arr_valid=%b after 7 words, required 0", arr_valid);
        end
        do_store(4'd7, 2'd2, 5'h1C, d[7], 4'hF);
        n_vec++;
        if ({arr_valid, arr_way, arr_set, arr_wmask} !== {1'b1, 4'b0100, 4'd7, 32'hFFFFFFFF}) begin
            n_err++;
            $display("FAIL full_ctrl: valid=%b way=%b set=%0d wmask=%h required 1,0100,7,ffffffff",
                     arr_valid, arr_way, arr_set, arr_wmask);
        end
        n_vec++;
        if (arr_wdata !== exp_line) begin
            n_err++;
            $display("FAIL full_data: got %h required %h", arr_wdata, exp_line);
        end
        arr_ready = 1'b1;
        step();
        arr_ready = 1'b0;
        n_vec++;
        if ({flush_done, pend_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL full_nodone: fdone=%b pend=%b required 0,0", flush_done, pend_valid);
        end
    endtask

    task automatic test_idle();
        int got;
        int z_seen;
        apply_reset();
        do_store(4'd2, 2'd3, 5'h10, 32'hCAFEF00D, 4'hF);
        got = -1;
        z_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (arr_valid && got < 0) got = k;
            if (arr_valid_z) z_seen++;
        end
        n_vec++;
        if (got != IDLE + 1) begin
            n_err++;
            $display("FAIL idle_timeout: arr_valid rose %0d cycles after accept, required %0d", got, IDLE + 1);
        end
        n_vec++;
        if ({z_seen != 0, pend_valid_z} !== 2'b01) begin
            n_err++;
            $display("FAIL idle_disabled: %0d drain cycles, pend=%b, required 0 drains and pend=1", z_seen, pend_valid_z);
        end
    endtask

    task automatic model_clear();
        m_set = '0;
        m_way = '0;
        for (int b = 0; b < 32; b++) begin
            m_line[b] = 8'h00;
            m_lm[b]   = 1'b0;
        end
    endtask

    task automatic model_put(input logic [4:0] off, input logic [31:0] d, input logic [3:0] m);
        int w;
        w = int'(off) / 4;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                m_line[w*4 + i] = d[i*8 +: 8];
                m_lm[w*4 + i]   = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        bit           e_ready, acc, nf, to;
        int           nbytes;
        logic [255:0] e_data;
        logic [31:0]  e_mask;
        logic [3:0]   e_way;
        apply_reset();
        m_pend = 0; m_drain = 0; m_flq = 0; m_fdone = 0; m_idle = 0;
        model_clear();
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid  = ($urandom_range(0, 9) < 6);
            req_set    = 4'($urandom_range(0, 1));
            req_way    = 2'($urandom_range(0, 1));
            req_offset = 5'($urandom_range(0, 31));
            req_wdata  = $urandom;
            req_wmask  = 4'($urandom_range(0, 15));
            flush      = ($urandom_range(0, 15) == 0);
            arr_ready  = ($urandom_range(0, 1) == 1);
            #2;
            e_ready = !m_pend || (!m_drain && req_set == m_set && req_way == m_way);
            for (int b = 0; b < 32; b++) begin
                e_mask[b]        = m_lm[b];
                e_data[b*8 +: 8] = m_lm[b] ? m_line[b] : 8'h00;
            end
            e_way = 4'b0001 << m_way;
            n_vec++;
            if (req_ready !== e_ready) begin
                n_err++;
                $display("FAIL rnd_ready cyc %0d: got %b required %b", cyc, req_ready, e_ready);
            end
            n_vec++;
            if ({arr_valid, pend_valid, flush_done} !== {m_drain, m_pend, m_fdone}) begin
                n_err++;
                $display("FAIL rnd_ctrl cyc %0d: valid/pend/fdone got %b required %b",
                         cyc, {arr_valid, pend_valid, flush_done}, {m_drain, m_pend, m_fdone});
            end
            if (m_drain) begin
                n_vec++;
                if ({arr_set, arr_way, arr_wmask, arr_wdata} !== {m_set, e_way, e_mask, e_data}) begin
                    n_err++;
                    $display("FAIL rnd_line cyc %0d: set=%0d way=%b wmask=%h required set=%0d way=%b wmask=%h (data %s)",
                             cyc, arr_set, arr_way, arr_wmask, m_set, e_way, e_mask,
                             (arr_wdata === e_data) ? "equal" : "differs");
                end
            end
            acc = req_valid && e_ready;
            nf  = 1'b0;
            if (m_drain) begin
                if (flush) m_flq = 1'b1;
                if (arr_ready) begin
                    nf = m_flq;
                    m_flq = 1'b0; m_pend = 1'b0; m_drain = 1'b0;
                    model_clear();
                end
            end else if (!m_pend) begin
                nf = flush;
                if (acc) begin
                    model_clear();
                    model_put(req_offset, req_wdata, req_wmask);
                    m_set = req_set; m_way = req_way;
                    m_pend = 1'b1; m_idle = 0;
                end
            end else begin
                to = (m_idle == IDLE);
                if (acc) begin
                    model_put(req_offset, req_wdata, req_wmask);
                    m_idle = 0;
                end else if (m_idle < IDLE) begin
                    m_idle++;
                end
                nbytes = 0;
                for (int b = 0; b < 32; b++) nbytes += int'(m_lm[b]);
                if (flush) m_flq = 1'b1;
                if ((req_valid && !e_ready) || flush || nbytes == 32 || to) m_drain = 1'b1;
            end
            m_fdone = nf;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0; flush = 1'b0; arr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_merge_flush();
        test_overlap();
        test_conflict();
        test_full_line();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
